// File: rtl/uart_tx_abaud.sv
// 8N1 UART transmitter with programmable bit period and an on-demand 0x55
// autobaud sync character for a far-end autobaud receiver.
module uart_tx_abaud #(
  parameter int unsigned DIV_WIDTH  = 16,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  preset,
  input  logic [DIV_WIDTH-1:0]  brg_div,
  input  logic                  abaud_tx,
  input  logic                  tx_valid,
  input  logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_ready,
  output logic                  busy,
  output logic                  UxTX,
  output logic                  UxTXIF
);

  localparam int unsigned BIT_W = $clog2(DATA_WIDTH);
  localparam logic [DATA_WIDTH-1:0] SYNC_CHAR = DATA_WIDTH'(8'h55);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [DIV_WIDTH-1:0]  div_q, div_d;
  logic [DIV_WIDTH-1:0]  baud_q, baud_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  tx_q, tx_d;
  logic                  txif_q, txif_d;
  logic                  baud_zero;

  assign baud_zero = (baud_q == '0);

  // Next-state, counters and shift register; line level follows the next state
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    txif_d  = 1'b0;

    if (state_q != IDLE) begin
      baud_d = baud_zero ? div_q : baud_q - DIV_WIDTH'(1);
    end

    case (state_q)
      IDLE: begin
        if (tx_valid) begin
          div_d   = brg_div;
          baud_d  = brg_div;
          bit_d   = '0;
          shift_d = abaud_tx ? SYNC_CHAR : tx_data;
          state_d = START;
        end
      end
      START: begin
        if (baud_zero) state_d = DATA;
      end
      DATA: begin
        if (baud_zero) begin
          shift_d = shift_q >> 1;
          bit_d   = bit_q + BIT_W'(1);
          if (bit_q == LAST_BIT) state_d = STOP;
        end
      end
      STOP: begin
        if (baud_zero) begin
          state_d = IDLE;
          txif_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge preset) begin
    if (preset) begin
      state_q <= IDLE;
      div_q   <= '0;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      txif_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      txif_q  <= txif_d;
    end
  end

  assign UxTX     = tx_q;
  assign UxTXIF   = txif_q;
  assign busy     = (state_q != IDLE);
  assign tx_ready = (state_q == IDLE) & ~preset;

endmodule

// File: tb/tb_uart_tx_abaud.sv
// Self-checking bench for uart_tx_abaud: expected line levels come from a
// frame model built directly from the 8N1 bit sequence and bit period.
module tb_uart_tx_abaud;

  logic        clk = 1'b0;
  logic        preset = 1'b1;
  logic [15:0] brg_div = '0;
  logic        abaud_tx = 1'b0;
  logic        tx_valid = 1'b0;
  logic [7:0]  tx_data = '0;
  logic        tx_ready, busy, UxTX, UxTXIF;

  int total = 0;
  int bad = 0;
  logic exp_q[$];

  uart_tx_abaud dut (
    .clk(clk), .preset(preset), .brg_div(brg_div), .abaud_tx(abaud_tx),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .busy(busy), .UxTX(UxTX), .UxTXIF(UxTXIF)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  // Append one frame (start, d0..d7 LSB first, stop), each bit held d cycles
  task automatic model_frame(input logic [7:0] b, input int d);
    for (int k = 0; k < 10; k++) begin
      logic lvl;
      if (k == 0) lvl = 1'b0;
      else if (k == 9) lvl = 1'b1;
      else lvl = b[k-1];
      for (int c = 0; c < d; c++) exp_q.push_back(lvl);
    end
  endtask

  // Present a word at a falling edge; acceptance happens at the next rising edge
  task automatic launch(input logic [15:0] dv, input logic ab, input logic [7:0] b);
    @(negedge clk);
    brg_div = dv; abaud_tx = ab; tx_data = b; tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic test_reset;
    preset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if (UxTX !== 1'b1 || busy !== 1'b0 || UxTXIF !== 1'b0 || tx_ready !== 1'b0) begin
        bad++;
        $display("FAIL reset_vals cyc=%0d got tx=%b busy=%b if=%b rdy=%b exp 1 0 0 0",
                 i, UxTX, busy, UxTXIF, tx_ready);
      end
    end
    preset = 1'b0;
    #1;
    total++;
    if (tx_ready !== 1'b1 || UxTX !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_release got rdy=%b tx=%b busy=%b exp 1 1 0", tx_ready, UxTX, busy);
    end
  endtask

  // Send one frame and check every line cycle plus the completion pulse
  task automatic test_frame(input string nm, input logic [15:0] dv, input logic ab,
                            input logic [7:0] b);
    int d;
    logic [7:0] word;
    d = int'(dv) + 1;
    word = ab ? 8'h55 : b;
    exp_q.delete();
    model_frame(word, d);
    launch(dv, ab, b);
    tx_data = ~b;
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (UxTX !== exp_q[i] || busy !== 1'b1 || UxTXIF !== 1'b0) begin
        bad++;
        $display("FAIL %s cyc=%0d got tx=%b busy=%b if=%b exp tx=%b busy=1 if=0",
                 nm, i, UxTX, busy, UxTXIF, exp_q[i]);
      end
      @(negedge clk);
    end
    total++;
    if (UxTXIF !== 1'b1 || tx_ready !== 1'b1 || UxTX !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL %s_done got if=%b rdy=%b tx=%b busy=%b exp 1 1 1 0",
               nm, UxTXIF, tx_ready, UxTX, busy);
    end
    @(negedge clk);
    total++;
    if (UxTXIF !== 1'b0) begin
      bad++;
      $display("FAIL %s_pulse_width got if=%b exp 0", nm, UxTXIF);
    end
  endtask

  task automatic test_random;
    for (int n = 0; n < 8; n++) begin
      logic [15:0] dv;
      logic ab;
      logic [7:0] b;
      dv = 16'($urandom_range(0, 4));
      ab = 1'($urandom_range(0, 1));
      b  = 8'($urandom);
      test_frame("random", dv, ab, b);
    end
  endtask

  task automatic test_back_to_back;
    exp_q.delete();
    model_frame(8'h01, 2);
    exp_q.push_back(1'b1);
    model_frame(8'h80, 2);
    @(negedge clk);
    brg_div = 16'd1; abaud_tx = 1'b0; tx_data = 8'h01; tx_valid = 1'b1;
    @(negedge clk);
    tx_data = 8'h80;
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (UxTX !== exp_q[i]) begin
        bad++;
        $display("FAIL b2b_line cyc=%0d got %b exp %b", i, UxTX, exp_q[i]);
      end
      if (i == 20) begin
        total++;
        if (UxTXIF !== 1'b1 || busy !== 1'b0) begin
          bad++;
          $display("FAIL b2b_gap got if=%b busy=%b exp 1 0", UxTXIF, busy);
        end
      end
      if (i == 21) tx_valid = 1'b0;
      @(negedge clk);
    end
    total++;
    if (UxTXIF !== 1'b1 || UxTX !== 1'b1) begin
      bad++;
      $display("FAIL b2b_done got if=%b tx=%b exp 1 1", UxTXIF, UxTX);
    end
  endtask

  task automatic test_midframe_ignored;
    exp_q.delete();
    model_frame(8'h0F, 3);
    launch(16'd2, 1'b0, 8'h0F);
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (UxTX !== exp_q[i]) begin
        bad++;
        $display("FAIL midframe_line cyc=%0d got %b exp %b", i, UxTX, exp_q[i]);
      end
      if (i == 4) begin
        brg_div = 16'd0; tx_data = 8'hAA; tx_valid = 1'b1;
      end
      if (i == 5) tx_valid = 1'b0;
      @(negedge clk);
    end
    total++;
    if (UxTXIF !== 1'b1) begin
      bad++;
      $display("FAIL midframe_done got if=%b exp 1", UxTXIF);
    end
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      total++;
      if (UxTX !== 1'b1 || busy !== 1'b0 || UxTXIF !== 1'b0) begin
        bad++;
        $display("FAIL midframe_no_second cyc=%0d got tx=%b busy=%b if=%b exp 1 0 0",
                 i, UxTX, busy, UxTXIF);
      end
    end
  endtask

  task automatic test_reset_midframe;
    exp_q.delete();
    model_frame(8'h3C, 2);
    launch(16'd1, 1'b0, 8'h3C);
    for (int i = 0; i < 8; i++) begin
      total++;
      if (UxTX !== exp_q[i]) begin
        bad++;
        $display("FAIL prereset_line cyc=%0d got %b exp %b", i, UxTX, exp_q[i]);
      end
      @(negedge clk);
    end
    preset = 1'b1;
    #1;
    total++;
    if (UxTX !== 1'b1 || busy !== 1'b0 || tx_ready !== 1'b0) begin
      bad++;
      $display("FAIL abort_immediate got tx=%b busy=%b rdy=%b exp 1 0 0", UxTX, busy, tx_ready);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (UxTXIF !== 1'b0 || UxTX !== 1'b1) begin
        bad++;
        $display("FAIL abort_hold cyc=%0d got if=%b tx=%b exp 0 1", i, UxTXIF, UxTX);
      end
    end
    preset = 1'b0;
    #1;
    total++;
    if (UxTX !== 1'b1 || busy !== 1'b0 || UxTXIF !== 1'b0) begin
      bad++;
      $display("FAIL abort_release got tx=%b busy=%b if=%b exp 1 0 0", UxTX, busy, UxTXIF);
    end
    test_frame("after_abort", 16'd2, 1'b0, 8'h5A);
  endtask

  initial begin
    test_reset();
    test_frame("frame_d1", 16'd0, 1'b0, 8'hA3);
    test_frame("autobaud", 16'd3, 1'b1, 8'hFF);
    test_random();
    test_back_to_back();
    test_midframe_ignored();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
